// File: rtl/tx_vita_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tx_vita_pkg
// Purpose : Shared constants for the TX VITA/CHDR sequence checker: header
//           field positions, event codes, CTRL bit indices and FSM encoding.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package tx_vita_pkg;

   // Header word (first beat) field positions
   localparam int HDR_TYPE_HI  = 63;
   localparam int HDR_TYPE_LO  = 62;
   localparam int HDR_HAS_TIME = 61;
   localparam int HDR_EOB      = 60;
   localparam int HDR_SEQ_HI   = 59;
   localparam int HDR_SEQ_LO   = 48;
   localparam int HDR_LEN_HI   = 47;
   localparam int HDR_LEN_LO   = 32;
   localparam int HDR_SID_HI   = 31;
   localparam int HDR_SID_LO   = 0;

   // Event codes placed in the upper half of error_code
   localparam logic [31:0] CODE_EOB_ACK   = 32'h0000_0001;
   localparam logic [31:0] CODE_SEQ_ERROR = 32'h0000_0004;

   // CTRL register layout
   localparam int             CTRL_W           = 3;
   localparam int             CTRL_CHECK_EN    = 0;
   localparam int             CTRL_DROP_ON_ERR = 1;
   localparam int             CTRL_EOB_ACK_EN  = 2;
   localparam logic [CTRL_W-1:0] CTRL_RESET    = 3'b101;

   typedef enum logic [1:0] {
      S_HDR  = 2'd0,
      S_BODY = 2'd1,
      S_DROP = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/setting_reg.sv
`default_nettype none
// ============================================================================
// Module  : setting_reg
// Purpose : One settings-bus register. Captures set_data[WIDTH-1:0] when a
//           write strobe hits ADDR and pulses 'changed' for one cycle after.
// Ports   : clk, reset (async active-low), set_stb/set_addr/set_data (bus),
//           out (register value), changed (one-cycle write pulse)
// Rev     : 1.0  initial release
// ============================================================================
module setting_reg #(
   parameter logic [7:0]       ADDR  = 8'd0,
   parameter int               WIDTH = 32,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             set_stb,
   input  logic [7:0]       set_addr,
   input  logic [31:0]      set_data,
   output logic [WIDTH-1:0] out,
   output logic             changed
);

   logic hit;
   logic unused_data;

   assign hit = set_stb & (set_addr == ADDR);
   // Narrow registers ignore the upper data bits.
   assign unused_data = ^set_data;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out     <= INIT;
         changed <= 1'b0;
      end else begin
         changed <= hit;
         if (hit) out <= set_data[WIDTH-1:0];
      end
   end

endmodule
`default_nettype wire

// File: rtl/tx_seq_checker.sv
`default_nettype none
// ============================================================================
// Module  : tx_seq_checker
// Purpose : Inline TX CHDR stage. Checks header seqnum continuity, raises
//           sequence-error / EOB-ack events for tx_responder and optionally
//           drops out-of-sequence packets. Data path is zero-latency.
// Ports   : clk, reset (async active-low), clear (sync)
//           set_stb/set_addr/set_data  settings bus (CTRL @BASE, RESYNC @BASE+1)
//           i_t*  input stream, o_t* output stream
//           ack_or_error, packet_consumed, seqnum, error_code, sid  events
//           err_count  saturating sequence-error count
// Rev     : 1.0  initial release
// ============================================================================
module tx_seq_checker
   import tx_vita_pkg::*;
#(
   parameter int unsigned BASE = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        set_stb,
   input  logic [7:0]  set_addr,
   input  logic [31:0] set_data,
   input  logic [63:0] i_tdata,
   input  logic        i_tlast,
   input  logic        i_tvalid,
   output logic        i_tready,
   output logic [63:0] o_tdata,
   output logic        o_tlast,
   output logic        o_tvalid,
   input  logic        o_tready,
   output logic        ack_or_error,
   output logic        packet_consumed,
   output logic [11:0] seqnum,
   output logic [63:0] error_code,
   output logic [31:0] sid,
   output logic [15:0] err_count
);

   logic [CTRL_W-1:0] ctrl;
   logic              resync_wr;
   logic              unused_ctrl_wr;
   logic              unused_resync_val;

   setting_reg #(.ADDR(8'(BASE)), .WIDTH(CTRL_W), .INIT(CTRL_RESET)) u_ctrl (
      .clk(clk), .reset(reset), .set_stb(set_stb), .set_addr(set_addr),
      .set_data(set_data), .out(ctrl), .changed(unused_ctrl_wr)
   );

   setting_reg #(.ADDR(8'(BASE + 1)), .WIDTH(1), .INIT(1'b0)) u_resync (
      .clk(clk), .reset(reset), .set_stb(set_stb), .set_addr(set_addr),
      .set_data(set_data), .out(unused_resync_val), .changed(resync_wr)
   );

   state_t      state;
   logic [11:0] last_seq;
   logic        resync;
   logic        eob_arm;   // current packet owes an EOB ack at its tlast
   logic        eob_pend;  // delayed EOB ack of a single-beat packet

   logic [11:0] rx_seq;
   logic [11:0] expected;
   logic        mismatch;
   logic        drop_pkt;
   logic        beat;
   logic        hdr_hs;
   logic        eob_req;

   assign rx_seq   = i_tdata[HDR_SEQ_HI:HDR_SEQ_LO];
   assign expected = last_seq + 12'd1;   // natural 12-bit wrap
   assign mismatch = ctrl[CTRL_CHECK_EN] & ~resync & (rx_seq != expected);

   always_comb begin
      drop_pkt = 1'b0;
      case (state)
         S_HDR:   drop_pkt = i_tvalid & mismatch & ctrl[CTRL_DROP_ON_ERR];
         S_DROP:  drop_pkt = 1'b1;
         default: drop_pkt = 1'b0;
      endcase
   end

   // While a single-beat packet's EOB ack is still queued, the next header is
   // held off for one cycle so its possible error event cannot collide with it.
   assign i_tready = reset & ~eob_pend & (drop_pkt | o_tready);
   assign o_tvalid = reset & ~eob_pend & i_tvalid & ~drop_pkt;
   assign o_tdata  = i_tdata;
   assign o_tlast  = i_tlast;

   assign beat    = i_tvalid & i_tready;
   assign hdr_hs  = beat & (state == S_HDR);
   assign eob_req = i_tdata[HDR_EOB] & ctrl[CTRL_EOB_ACK_EN] & ~drop_pkt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= S_HDR;
         last_seq        <= 12'd0;
         resync          <= 1'b1;
         eob_arm         <= 1'b0;
         eob_pend        <= 1'b0;
         ack_or_error    <= 1'b0;
         packet_consumed <= 1'b0;
         seqnum          <= 12'd0;
         error_code      <= 64'd0;
         sid             <= 32'd0;
         err_count       <= 16'd0;
      end else if (clear) begin
         state           <= S_HDR;
         last_seq        <= 12'd0;
         resync          <= 1'b1;
         eob_arm         <= 1'b0;
         eob_pend        <= 1'b0;
         ack_or_error    <= 1'b0;
         packet_consumed <= 1'b0;
         seqnum          <= 12'd0;
         error_code      <= 64'd0;
         sid             <= 32'd0;
         err_count       <= 16'd0;
      end else begin
         ack_or_error    <= 1'b0;
         packet_consumed <= 1'b0;
         eob_pend        <= 1'b0;

         if (eob_pend) begin
            ack_or_error <= 1'b1;
            error_code   <= {CODE_EOB_ACK, 32'h0};
         end

         if (hdr_hs) begin
            seqnum   <= rx_seq;
            sid      <= i_tdata[HDR_SID_HI:HDR_SID_LO];
            last_seq <= rx_seq;
            resync   <= 1'b0;
            eob_arm  <= eob_req;
            if (mismatch) begin
               ack_or_error <= 1'b1;
               error_code   <= {CODE_SEQ_ERROR, 4'h0, expected, 4'h0, rx_seq};
               if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            end
            if (i_tlast) begin
               packet_consumed <= 1'b1;
               eob_pend        <= eob_req;
               state           <= S_HDR;
            end else begin
               state <= drop_pkt ? S_DROP : S_BODY;
            end
         end else if (beat && i_tlast) begin
            packet_consumed <= 1'b1;
            if (state == S_BODY && eob_arm) begin
               ack_or_error <= 1'b1;
               error_code   <= {CODE_EOB_ACK, 32'h0};
            end
            eob_arm <= 1'b0;
            state   <= S_HDR;
         end

         // A RESYNC write landing on a header cycle applies to the next header.
         if (resync_wr) resync <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: doc/tx_seq_checker.md
Name: tx_seq_checker

Overview:
- Inline stage on the 64-bit TX VITA/CHDR stream, directly upstream of tx_responder.
- Parses each packet header and checks sequence-number continuity against the previous packet.
- Drives tx_responder's event inputs: ack_or_error, packet_consumed, seqnum, error_code, sid.
- Forwards packets to the TX deframer, optionally dropping out-of-sequence packets.

Parameters:
- BASE, 0: settings-bus base address. Registers live at BASE+0 (CTRL) and BASE+1 (RESYNC).

Ports:
- clk  in  1  single clock domain for all logic.
- reset  in  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.
- clear  in  1  synchronous clear; same effect as reset on state and counters, CTRL keeps its value.
- set_stb  in  1  settings-bus write strobe.
- set_addr  in  8  settings-bus address.
- set_data  in  32  settings-bus data.
- i_tdata  in  64  input stream data.
- i_tlast  in  1  input end of packet.
- i_tvalid  in  1  input valid.
- i_tready  out  1  input ready.
- o_tdata  out  64  output stream data.
- o_tlast  out  1  output end of packet.
- o_tvalid  out  1  output valid.
- o_tready  in  1  output ready.
- ack_or_error  out  1  one-cycle pulse; error_code is valid in the same cycle.
- packet_consumed  out  1  one-cycle pulse at the end of every packet, forwarded or dropped.
- seqnum  out  12  seqnum of the current/last packet; valid with packet_consumed.
- error_code  out  64  event body.
- sid  out  32  SID of the current packet.
- err_count  out  16  saturating count of sequence errors.

Behaviour:
- Header word, first beat:
  - [63:62] type; [61] has_time; [60] EOB; [59:48] seqnum; [47:32] length; [31:0] SID.
  - If has_time, the second beat is the timestamp.
- CTRL register (BASE+0):
  - bit0 check_en, bit1 drop_on_err, bit2 eob_ack_en.
  - Reset value 3'b101.
- Any write to BASE+1 sets the resync flag: the next header is accepted as the new reference without any check.
- Reset values: i_tready 0, o_tvalid 0, ack_or_error 0, packet_consumed 0, seqnum 0, error_code 0, sid 0, err_count 0. Resync flag is set.
- FSM:
  - S_HDR: waits for the i_tvalid & i_tready beat and latches seqnum and sid.
    - If the packet is single-beat (tlast), go back to S_HDR.
    - Otherwise, drop_pkt selects S_DROP; else go to S_BODY.
  - S_BODY: forwards beats and returns to S_HDR on the tlast handshake.
  - S_DROP: same as S_BODY but nothing is output.
- Pass-through is combinational, zero latency:
  - o_tdata = i_tdata, o_tlast = i_tlast.
  - o_tvalid = i_tvalid & ~drop_pkt.
  - i_tready = drop_pkt | o_tready.
  - While in reset, i_tready and o_tvalid are held at 0.
- Sequence check on the header beat:
  - expected = last_seq + 1, mod 4096 (12-bit wrap: 4095 -> 0 is in sequence).
  - Mismatch only when check_en=1 and the resync flag is clear.
  - last_seq is updated with the received seqnum on every header, match or not; resync clears on that header.
  - drop_pkt = mismatch & drop_on_err. It is decided combinationally on the header beat, so that beat is also withheld, and it is held until the packet's tlast.
- Error event:
  - Registered pulse one cycle after the header handshake.
  - error_code = {32'h0000_0004, 4'h0, expected, 4'h0, received}.
  - err_count increments, saturating at 16'hFFFF.
- EOB ack:
  - If eob_ack_en and the header has EOB=1, pulse one cycle after the tlast handshake.
  - error_code = {32'h0000_0001, 32'h0}.
  - Not emitted for dropped packets.
- packet_consumed pulses one cycle after the tlast handshake; seqnum and sid hold until the next header.
- Single-beat packet (header with tlast):
  - The error pulse comes in the cycle after the handshake.
  - The EOB ack is delayed one further cycle, so the two never coincide.
  - Generally, ack_or_error is never asserted in two consecutive cycles unless they are for distinct events.
- A CTRL write mid-packet takes effect at the next header. A RESYNC write mid-packet does not affect the current packet.
- Reset or clear mid-packet: FSM returns to S_HDR, and the remaining beats of that packet are parsed as a header. Upstream must flush alongside clear.

Decomposition:
- Package tx_vita_pkg holds:
  - header field bit positions;
  - codes CODE_EOB_ACK=32'h1 and CODE_SEQ_ERROR=32'h4;
  - CTRL bit indices;
  - state encoding.
- One sub-module, setting_reg instances, for CTRL and RESYNC decode. All other logic is flat.

Test Plan:
- Reset, then packets with seq 0, 1, 2 (4 beats each, o_tready=1) -> data unchanged on o_*, three packet_consumed pulses with seqnum 0/1/2, no ack_or_error, err_count=0.
- Seq 4094, 4095, 0 -> no error; wrap-around treated as in sequence.
- Seq 5, 7 with drop_on_err=0 -> error pulse, error_code=64'h0000_0004_0006_0007, packet 7 forwarded, err_count=1.
- Same with CTRL=3'b111 -> packet 7 never appears on o_*, i_tready=1 throughout, packet_consumed still pulses, next seq 8 passes with no error.
- EOB=1 packet, eob_ack_en=1, o_tready toggling 50% -> ack_or_error with 64'h0000_0001_0000_0000 exactly one cycle after the final handshake.
- RESYNC write, then seq 100 after 3 -> no error; reset asserted mid-body -> o_tvalid drops immediately, all outputs at reset values.
